// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_src1_i,
  input  logic [31:0] req0_src2_i,
  input  logic [3:0]  req0_ctrl_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_src1_i,
  input  logic [31:0] req1_src2_i,
  input  logic [3:0]  req1_ctrl_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_err_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        ptr;
  logic [31:0] op_src1;
  logic [31:0] op_src2;
  logic [3:0]  op_ctrl;
  logic        op_id;
  logic        grant_any;
  logic        grant_id;
  logic        accept;
  logic        legal;

  // ptr only breaks ties; a lone requester always wins
  always_comb begin
    grant_any = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      grant_id = ptr;
    end else begin
      grant_id = ~req0_valid_i;
    end
  end

  always_comb begin
    state_nxt    = state;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    case (state)
      IDLE: begin
        if (!rst_i && grant_any) begin
          req0_ready_o = ~grant_id;
          req1_ready_o = grant_id;
          state_nxt    = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign accept = req0_ready_o | req1_ready_o;
  assign legal  = (op_ctrl == 4'd0) || (op_ctrl == 4'd1) || (op_ctrl == 4'd2) ||
                  (op_ctrl == 4'd6) || (op_ctrl == 4'd7);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr          <= 1'b0;
      op_src1      <= '0;
      op_src2      <= '0;
      op_ctrl      <= '0;
      op_id        <= 1'b0;
      rsp_id_o     <= 1'b0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
      rsp_err_o    <= 1'b0;
    end else begin
      if (accept) begin
        op_src1 <= grant_id ? req1_src1_i : req0_src1_i;
        op_src2 <= grant_id ? req1_src2_i : req0_src2_i;
        op_ctrl <= grant_id ? req1_ctrl_i : req0_ctrl_i;
        op_id   <= grant_id;
        ptr     <= ~grant_id;
      end
      // illegal codes never expose whatever the ALU produced
      if (state == EXEC) begin
        rsp_id_o     <= op_id;
        rsp_err_o    <= ~legal;
        rsp_result_o <= legal ? alu_result_i : 32'd0;
        rsp_zero_o   <= legal ? alu_zero_i : 1'b1;
      end
    end
  end

  assign alu_src1_o  = op_src1;
  assign alu_src2_o  = op_src2;
  assign alu_ctrl_o  = op_ctrl;
  assign rsp_valid_o = (state == RESP);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, ALU control width fixed at 4 bits.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 req0_valid_i  input  1  requester 0 has an operation pending.
REQ-005 req0_ready_o  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_src1_i / req0_src2_i  input  32 each  requester 0 operands.
REQ-007 req0_ctrl_i  input  4  requester 0 ALU op: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT.
REQ-008 req1_valid_i, req1_ready_o, req1_src1_i, req1_src2_i, req1_ctrl_i  same widths and meaning for requester 1.
REQ-009 alu_src1_o / alu_src2_o  output  32 each  operands driven to the shared ALU.
REQ-010 alu_ctrl_o  output  4  control code driven to the shared ALU.
REQ-011 alu_result_i  input  32  combinational ALU result.
REQ-012 alu_zero_i  input  1  combinational ALU zero flag.
REQ-013 rsp_valid_o  output  1  response available.
REQ-014 rsp_ready_i  input  1  consumer accepts response.
REQ-015 rsp_id_o  output  1  requester index owning the response.
REQ-016 rsp_result_o  output  32  captured result.
REQ-017 rsp_zero_o  output  1  captured zero flag.
REQ-018 rsp_err_o  output  1  op code was not one of 0,1,2,6,7.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-020 IDLE: grant is combinational; with one valid requester, that requester is granted; with both valid, the requester not granted last is granted (round-robin pointer).
REQ-021 reqN_ready_o SHALL be 1 only in IDLE for the granted requester; never both high; 0 in EXEC and RESP.
REQ-022 Acceptance (valid & ready) SHALL latch src1, src2, ctrl, requester id into operand registers, flip the pointer to favour the other requester, and move to EXEC.
REQ-023 alu_src1_o, alu_src2_o, alu_ctrl_o SHALL be driven only from the operand registers; they hold their last value outside EXEC.
REQ-024 EXEC lasts exactly one cycle; at its end, rsp_result_o, rsp_zero_o, rsp_id_o, rsp_err_o are registered and the FSM moves to RESP.
REQ-025 Illegal ctrl: rsp_err_o=1, rsp_result_o=0, rsp_zero_o=1, regardless of alu_result_i.
REQ-026 RESP: rsp_valid_o=1; response registers stable until rsp_ready_i=1; on that handshake rsp_valid_o drops and FSM returns to IDLE next cycle.
REQ-027 Latency: accept in cycle N -> rsp_valid_o=1 in cycle N+2; if rsp_ready_i held high, next acceptance no earlier than cycle N+3.
REQ-028 Valid dropped by an ungranted requester SHALL leave the pointer unchanged; requester valid/operand changes after acceptance SHALL not affect the in-flight op.
REQ-029 No starvation: with both requesters continuously valid, grants SHALL strictly alternate 0,1,0,1...
REQ-030 rsp_valid_o SHALL not depend combinationally on rsp_ready_i or any requester input.

Reset
REQ-031 rst_i=1 at a rising edge: FSM->IDLE, pointer favours requester 0, rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, rsp_zero_o=0, rsp_err_o=0, operand registers and alu_*_o=0.
REQ-032 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight op with no response issued; reqN_ready_o=0 while rst_i=1.

Verification
REQ-033 req0 ADD 5,7 alone, rsp_ready_i=1 -> req0_ready_o in accept cycle, rsp_valid_o two cycles later, rsp_result_o=12, rsp_zero_o=0, rsp_id_o=0.
REQ-034 Both valid from reset, req0 SUB 9,9, req1 SLT 3,4 -> req0 granted first (result 0, zero 1, id 0), then req1 (result 1, zero 0, id 1).
REQ-035 Both continuously valid for 6 grants -> ids 0,1,0,1,0,1; never both ready high in one cycle.
REQ-036 req1 ctrl=4'd3, operands 1,1 -> rsp_err_o=1, rsp_result_o=0, rsp_zero_o=1.
REQ-037 rsp_ready_i=0 for 5 cycles in RESP with req1 valid -> rsp outputs stable, req1_ready_o=0; rsp_ready_i=1 then req1 accepted one cycle after the handshake.
REQ-038 rst_i asserted during EXEC -> next cycle state IDLE, rsp_valid_o=0, no response for the discarded op; subsequent req0 OR 0xF0,0x0F returns 0xFF.
